// File: rtl/adc_avg_fifo_pkg.sv
// Shared constants, filter states and width helper
// for the ADC averaging FIFO block.
package adc_avg_fifo_pkg;

   localparam int ADC_DW    = 16;
   localparam int DEF_SHIFT = 3;
   localparam int DEF_DECIM = 4;
   localparam int DEF_DEPTH = 8;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/adc_avg_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with
// extra-bit pointers; reusable by other bus peripherals.
module sync_fifo
   import adc_avg_fifo_pkg::*;
#(
   parameter int DW    = ADC_DW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DW-1:0]         din,
   input  logic                  pop,
   output logic [DW-1:0]         dout,
   output logic                  empty,
   output logic                  full,
   output logic [clog2(DEPTH):0] level,
   output logic                  dropped
);

   localparam int AW = clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          do_pop;
   logic          do_push;

   assign level   = wptr - rptr;
   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same cycle, so full+pop still accepts.
   assign do_push = push & (~full | do_pop);
   assign dropped = push & full & ~do_pop;
   assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/adc_avg_fifo.sv
// EMA filter, decimator and FIFO for ADC samples.
// Define ADC_THRESH_IRQ_EN to add the threshold-crossing irq.
module adc_avg_fifo
   import adc_avg_fifo_pkg::*;
#(
   parameter int DW    = ADC_DW,
   parameter int SHIFT = DEF_SHIFT,
   parameter int DECIM = DEF_DECIM,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DW-1:0]         in_data,
   input  logic                  in_stb,
   input  logic                  rd_en,
   output logic [DW-1:0]         rd_data,
   output logic                  fifo_empty,
   output logic [clog2(DEPTH):0] fifo_level,
   output logic                  overflow,
   input  logic                  ovf_clr,
   output logic [DW-1:0]         filt_out
`ifdef ADC_THRESH_IRQ_EN
   ,
   input  logic [DW-1:0]         thresh,
   output logic                  irq,
   input  logic                  irq_clr
`endif
);

   localparam int AWID = DW + SHIFT;

   state_t          state;
   state_t          state_nxt;
   logic [AWID-1:0] acc;
   logic [AWID-1:0] acc_nxt;
   logic [AWID:0]   sum;
   logic [7:0]      dec_cnt;
   logic            wrap_q;
   logic            dropped;
   logic            unused_full;

   assign filt_out = acc[AWID-1:SHIFT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_PRIME;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
      end
   end

   // acc holds filt_out<<SHIFT plus a fraction, so the sum never wraps.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      sum       = {1'b0, acc} + (AWID+1)'(in_data)
                - (AWID+1)'(filt_out);
      unique case (state)
         ST_PRIME: if (in_stb) begin
            acc_nxt   = AWID'(in_data) << SHIFT;
            state_nxt = ST_RUN;
         end
         ST_RUN: if (in_stb) begin
            acc_nxt = sum[AWID-1:0];
         end
         default: state_nxt = ST_PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt <= '0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (in_stb) begin
            if (dec_cnt == 8'(DECIM - 1)) begin
               dec_cnt <= '0;
               wrap_q  <= 1'b1;
            end else begin
               dec_cnt <= dec_cnt + 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (wrap_q),
      .din     (filt_out),
      .pop     (rd_en),
      .dout    (rd_data),
      .empty   (fifo_empty),
      .full    (unused_full),
      .level   (fifo_level),
      .dropped (dropped)
   );

   always_ff @(posedge clk) begin
      if (rst) overflow <= 1'b0;
      else     overflow <= dropped | (overflow & ~ovf_clr);
   end

`ifdef ADC_THRESH_IRQ_EN
   logic below;

   // below starts at 1 so a priming sample at/above thresh fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         below <= 1'b1;
         irq   <= 1'b0;
      end else begin
         below <= (filt_out < thresh);
         irq   <= (below & (filt_out >= thresh))
                | (irq & ~irq_clr);
      end
   end
`endif

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed self-checking bench for adc_avg_fifo;
// u1: SHIFT=3 DECIM=1, u3: SHIFT=1 DECIM=4.
`timescale 1ns/1ps
module tb_adc_avg_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_stb;
   logic        rd_en;
   logic        ovf_clr;
   logic [15:0] thresh;
   logic        irq_clr;

   logic [15:0] rd1, filt1, rd3, filt3;
   logic        emp1, ovf1, emp3, ovf3;
   logic [3:0]  lvl1, lvl3;
   logic        irq1, irq3;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adc_avg_fifo #(
      .DW(16), .SHIFT(3), .DECIM(1), .DEPTH(8)
   ) u1 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_stb     (in_stb),
      .rd_en      (rd_en),
      .rd_data    (rd1),
      .fifo_empty (emp1),
      .fifo_level (lvl1),
      .overflow   (ovf1),
      .ovf_clr    (ovf_clr),
      .filt_out   (filt1)
`ifdef ADC_THRESH_IRQ_EN
      ,
      .thresh     (thresh),
      .irq        (irq1),
      .irq_clr    (irq_clr)
`endif
   );

   adc_avg_fifo #(
      .DW(16), .SHIFT(1), .DECIM(4), .DEPTH(8)
   ) u3 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_stb     (in_stb),
      .rd_en      (rd_en),
      .rd_data    (rd3),
      .fifo_empty (emp3),
      .fifo_level (lvl3),
      .overflow   (ovf3),
      .ovf_clr    (ovf_clr),
      .filt_out   (filt3)
`ifdef ADC_THRESH_IRQ_EN
      ,
      .thresh     (thresh),
      .irq        (irq3),
      .irq_clr    (irq_clr)
`endif
   );

`ifndef ADC_THRESH_IRQ_EN
   assign irq1 = 1'b0;
   assign irq3 = 1'b0;
`endif

   task automatic check(input string tag,
                        input int got,
                        input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample(input int d);
      in_data = 16'(d);
      in_stb  = 1'b1;
      cyc(1);
      in_stb  = 1'b0;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      in_stb  = 1'b0;
      rd_en   = 1'b0;
      ovf_clr = 1'b0;
      irq_clr = 1'b0;
      cyc(2);
      rst     = 1'b0;
   endtask

   int exp3 [8] = '{1, 1, 2, 3, 4, 5, 6, 7};
   int exp4 [8] = '{700, 612, 536, 469,
                    410, 359, 314, 240};

   initial begin
      in_data = '0;
      thresh  = 16'd600;
      do_reset();

      // reset state
      check("rst_filt", filt1, 0);
      check("rst_empty", emp1, 1);
      check("rst_level", lvl1, 0);
      check("rst_ovf", ovf1, 0);
      check("rst_rd", rd1, 0);

      // 1: constant 512, stream through with rd_en held
      rd_en   = 1'b1;
      in_data = 16'd512;
      in_stb  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("t1_filt", filt1, 512);
         if (i > 0) begin
            check("t1_lvl", lvl1, 1);
            check("t1_rd", rd1, 512);
         end
      end
      in_stb = 1'b0;
      cyc(1);
      check("t1_lvl_last", lvl1, 1);
      check("t1_rd_last", rd1, 512);
      cyc(1);
      check("t1_empty", emp1, 1);
      check("t1_ovf", ovf1, 0);
      rd_en = 1'b0;

      // 2: step response
      do_reset();
      sample(0);
      check("t2_f0", filt1, 0);
      sample(1024);
      check("t2_f1", filt1, 128);
      sample(1024);
      check("t2_f2", filt1, 240);
      cyc(1);
      check("t2_hold", filt1, 240);

      // 3: decimate by 4, SHIFT=1
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sample(i + 1);
         check("t3_filt", filt3, exp3[i]);
         if (i == 3) check("t3_lvl4", lvl3, 0);
         if (i == 4) begin
            check("t3_lvl5", lvl3, 1);
            check("t3_rd5", rd3, 3);
         end
      end
      check("t3_lvl8", lvl3, 1);
      cyc(1);
      check("t3_lvl9", lvl3, 2);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      check("t3_rd2", rd3, 7);
      check("t3_lvl1", lvl3, 1);

      // 4: nine pushes, no reads
      do_reset();
      sample(800);
      for (int i = 0; i < 8; i++) sample(0);
      cyc(1);
      check("t4_lvl", lvl1, 8);
      check("t4_ovf", ovf1, 1);
      check("t4_head", rd1, 800);

      // 5: full with push+pop, then clear vs drop
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("t5_clr", ovf1, 0);
      sample(0);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      check("t5_lvl", lvl1, 8);
      check("t5_ovf", ovf1, 0);
      sample(0);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("t5_setwins", ovf1, 1);
      check("t5_lvl2", lvl1, 8);
      for (int i = 0; i < 8; i++) begin
         check("t5_pop", rd1, exp4[i]);
         rd_en = 1'b1;
         cyc(1);
         rd_en = 1'b0;
      end
      check("t5_empty", emp1, 1);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      check("t5_popempty", lvl1, 0);

`ifdef ADC_THRESH_IRQ_EN
      // 6: threshold irq on the ramp 0 -> 1000
      do_reset();
      sample(0);
      cyc(1);
      check("t6_irq0", irq1, 0);
      for (int i = 0; i < 6; i++) sample(1000);
      check("t6_f6", filt1, 551);
      check("t6_irq6", irq1, 0);
      sample(1000);
      check("t6_f7", filt1, 607);
      check("t6_irq7", irq1, 0);
      cyc(1);
      check("t6_irqset", irq1, 1);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check("t6_irqclr", irq1, 0);
      sample(1000);
      check("t6_f8", filt1, 656);
      cyc(2);
      check("t6_norefire", irq1, 0);
      do_reset();
      check("t6_rst_filt", filt1, 0);
      check("t6_rst_empty", emp1, 1);
      check("t6_rst_irq", irq1, 0);
      check("t6_rst_ovf", ovf1, 0);
      sample(700);
      cyc(1);
      check("t6_prime_irq", irq1, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
